read_operation_ctrl: RTL and testbench

//  Read-side controller for the 7-entry register file of the factorial datapath.
//  It accepts a burst read request (start address, beat count) and streams register

---
 rtl/read_operation_ctrl.sv | 129 ++++++++++++
 tb/tb_read_operation_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_operation_ctrl.sv
// Read-side burst controller for the 7-entry factorial register file.
// Define READ_BYPASS_EN to forward same-cycle write data (wEn/wData) into loaded beats.
module read_operation_ctrl #(
    parameter int DATA_W = 32,
    parameter int NREG   = 7,
    parameter int AW     = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   rd_req,
    input  logic [AW-1:0]          rd_addr,
    input  logic [AW-1:0]          rd_len,
    input  logic [NREG*DATA_W-1:0] regs_flat,
    input  logic [NREG-1:0]        wEn,
    input  logic [DATA_W-1:0]      wData,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_last,
    output logic                   rd_busy,
    output logic                   rd_err
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NREG - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     next_addr;
    logic [AW-1:0]     load_addr;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] data_d;
    logic              valid_d, last_d, busy_d, err_d;

    // Beat counts above the register count collapse to a full-file burst.
    function automatic logic [AW-1:0] clamp_len(input logic [AW-1:0] len);
        return (len > LAST_ADDR) ? LAST_ADDR : len;
    endfunction

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + AW'(1);
    endfunction

    function automatic logic [DATA_W-1:0] reg_word(input logic [NREG*DATA_W-1:0] flat,
                                                   input logic [AW-1:0]          a);
        return flat[a*DATA_W +: DATA_W];
    endfunction

    assign next_addr = wrap_inc(addr_q);
    assign load_addr = (state_q == IDLE) ? rd_addr : next_addr;

`ifdef READ_BYPASS_EN
    // A write landing on the same edge as the load wins over the stale file value.
    assign load_data = wEn[load_addr] ? wData : reg_word(regs_flat, load_addr);
`else
    logic unused_bypass;
    assign unused_bypass = ^{wEn, wData};
    assign load_data     = reg_word(regs_flat, load_addr);
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = rd_data;
        valid_d = rd_valid;
        last_d  = rd_last;
        busy_d  = rd_busy;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rd_req) begin
                    if (rd_addr > LAST_ADDR) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = STREAM;
                        addr_d  = rd_addr;
                        cnt_d   = clamp_len(rd_len);
                        data_d  = load_data;
                        valid_d = 1'b1;
                        last_d  = (clamp_len(rd_len) == '0);
                        busy_d  = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (rd_valid && rd_ready) begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                    end else begin
                        addr_d = next_addr;
                        cnt_d  = cnt_q - AW'(1);
                        data_d = load_data;
                        last_d = (cnt_q == AW'(1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_busy  <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            rd_data  <= data_d;
            rd_valid <= valid_d;
            rd_last  <= last_d;
            rd_busy  <= busy_d;
            rd_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_read_operation_ctrl.sv
// Scoreboard bench for read_operation_ctrl: expected beats queued at request time, popped on handshake.
module tb_read_operation_ctrl;
    localparam int DATA_W = 32;
    localparam int NREG   = 7;
    localparam int AW     = 3;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   rd_req;
    logic [AW-1:0]          rd_addr;
    logic [AW-1:0]          rd_len;
    logic [NREG*DATA_W-1:0] regs_flat;
    logic [NREG-1:0]        wEn;
    logic [DATA_W-1:0]      wData;
    logic                   rd_ready;
    logic                   rd_valid;
    logic [DATA_W-1:0]      rd_data;
    logic                   rd_last;
    logic                   rd_busy;
    logic                   rd_err;

    logic [DATA_W-1:0] regs [NREG];

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t sb_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    read_operation_ctrl #(.DATA_W(DATA_W), .NREG(NREG), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
        .regs_flat(regs_flat), .wEn(wEn), .wData(wData), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_busy(rd_busy),
        .rd_err(rd_err)
    );

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
    end

    always #5 clk = ~clk;

    // Expected beats for a burst: clamp length, walk addresses with 6->0 wrap.
    task automatic push_burst(input int a, input int len);
        int n;
        n = ((len > NREG - 1) ? NREG - 1 : len) + 1;
        for (int k = 0; k < n; k++) begin
            sb_q.push_back('{data: regs[a], last: (k == n - 1)});
            a = (a == NREG - 1) ? 0 : a + 1;
        end
    endtask

    task automatic issue_req(input int a, input int len);
        rd_addr = AW'(a);
        rd_len  = AW'(len);
        rd_req  = 1'b1;
        @(negedge clk);
        rd_req  = 1'b0;
    endtask

    task automatic test_reset;
        rd_req = 0; rd_addr = 0; rd_len = 0; wEn = 0; wData = 0; rd_ready = 0;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({rd_valid, rd_last, rd_busy, rd_err} !== 4'b0 || rd_data !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%b last=%b busy=%b err=%b data=%h, expected all zero",
                     rd_valid, rd_last, rd_busy, rd_err, rd_data);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_burst(input string name, input int a, input int len);
        beat_t e;
        int    budget;
        rd_ready = 1'b1;
        push_burst(a, len);
        issue_req(a, len);
        budget = 0;
        while (sb_q.size() > 0 && budget < 20) begin
            vectors++;
            if (!rd_valid) begin
                miscompares++;
                $display("FAIL %s bubble: got rd_valid=0, expected 1", name);
            end else begin
                e = sb_q.pop_front();
                if (rd_data !== e.data || rd_last !== e.last) begin
                    miscompares++;
                    $display("FAIL %s beat: got data=%h last=%b, expected data=%h last=%b",
                             name, rd_data, rd_last, e.data, e.last);
                end
            end
            @(negedge clk);
            budget++;
        end
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s timeout: %0d beats outstanding, expected 0", name, sb_q.size());
            sb_q.delete();
        end
        vectors++;
        if (rd_busy !== 1'b0 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s end: got busy=%b valid=%b, expected 0 0", name, rd_busy, rd_valid);
        end
    endtask

    task automatic test_backpressure;
        beat_t e;
        int    budget;
        rd_ready = 1'b0;
        push_burst(1, 1);
        issue_req(1, 1);
        for (int c = 0; c < 3; c++) begin
            rd_req = 1'b1; rd_addr = 3'd4; rd_len = 3'd0;
            vectors++;
            if (rd_valid !== 1'b1 || rd_data !== sb_q[0].data || rd_last !== 1'b0) begin
                miscompares++;
                $display("FAIL backpressure_hold: got valid=%b data=%h last=%b, expected 1 %h 0",
                         rd_valid, rd_data, rd_last, sb_q[0].data);
            end
            @(negedge clk);
        end
        rd_req   = 1'b0;
        rd_ready = 1'b1;
        budget   = 0;
        while (sb_q.size() > 0 && budget < 10) begin
            if (rd_valid) begin
                e = sb_q.pop_front();
                vectors++;
                if (rd_data !== e.data || rd_last !== e.last) begin
                    miscompares++;
                    $display("FAIL backpressure_beat: got data=%h last=%b, expected data=%h last=%b",
                             rd_data, rd_last, e.data, e.last);
                end
            end
            @(negedge clk);
            budget++;
        end
        vectors++;
        if (sb_q.size() != 0 || budget != 2) begin
            miscompares++;
            $display("FAIL backpressure_drain: got %0d cycles/%0d left, expected 2 cycles/0 left",
                     budget, sb_q.size());
            sb_q.delete();
        end
        vectors++;
        if (rd_valid !== 1'b0 || rd_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL backpressure_ignored_req: got valid=%b busy=%b, expected 0 0", rd_valid, rd_busy);
        end
    endtask

    task automatic test_error;
        rd_ready = 1'b1;
        issue_req(7, 0);
        vectors++;
        if (rd_err !== 1'b1 || rd_valid !== 1'b0 || rd_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL error_pulse: got err=%b valid=%b busy=%b, expected 1 0 0", rd_err, rd_valid, rd_busy);
        end
        @(negedge clk);
        vectors++;
        if (rd_err !== 1'b0 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL error_one_cycle: got err=%b valid=%b, expected 0 0", rd_err, rd_valid);
        end
    endtask

    task automatic test_back_to_back;
        rd_ready = 1'b1;
        rd_addr = 3'd6; rd_len = 3'd0; rd_req = 1'b1;
        @(negedge clk);
        rd_addr = 3'd0;
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== regs[6] || rd_last !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first: got valid=%b data=%h last=%b, expected 1 %h 1",
                     rd_valid, rd_data, rd_last, regs[6]);
        end
        @(negedge clk);
        vectors++;
        if (rd_valid !== 1'b0 || rd_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_gap: got valid=%b busy=%b, expected 0 0", rd_valid, rd_busy);
        end
        @(negedge clk);
        rd_req = 1'b0;
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== regs[0] || rd_last !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_second: got valid=%b data=%h last=%b, expected 1 %h 1",
                     rd_valid, rd_data, rd_last, regs[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_bypass_snapshot;
        logic [DATA_W-1:0] exp_data;
        logic [DATA_W-1:0] saved;
`ifdef READ_BYPASS_EN
        exp_data = 32'hDEAD;
`else
        exp_data = regs[3];
`endif
        rd_ready = 1'b0;
        wEn   = 7'b0001000;
        wData = 32'hDEAD;
        issue_req(3, 0);
        wEn = '0;
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== exp_data || rd_last !== 1'b1) begin
            miscompares++;
            $display("FAIL bypass_load: got valid=%b data=%h last=%b, expected 1 %h 1",
                     rd_valid, rd_data, rd_last, exp_data);
        end
        saved   = regs[3];
        regs[3] = 32'h0BAD_F00D;
        @(negedge clk);
        vectors++;
        if (rd_data !== exp_data) begin
            miscompares++;
            $display("FAIL snapshot_hold: got data=%h, expected %h", rd_data, exp_data);
        end
        regs[3]  = saved;
        rd_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (rd_valid !== 1'b0 || rd_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bypass_end: got valid=%b busy=%b, expected 0 0", rd_valid, rd_busy);
        end
    endtask

    task automatic test_reset_mid_burst;
        beat_t e;
        rd_ready = 1'b1;
        issue_req(0, 4);
        repeat (2) @(negedge clk);
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== regs[2]) begin
            miscompares++;
            $display("FAIL midburst_pre: got valid=%b data=%h, expected 1 %h", rd_valid, rd_data, regs[2]);
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({rd_valid, rd_last, rd_busy, rd_err} !== 4'b0 || rd_data !== '0) begin
            miscompares++;
            $display("FAIL midburst_reset: got valid=%b last=%b busy=%b err=%b data=%h, expected all zero",
                     rd_valid, rd_last, rd_busy, rd_err, rd_data);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        push_burst(0, 0);
        issue_req(0, 0);
        e = sb_q.pop_front();
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== e.data || rd_last !== e.last) begin
            miscompares++;
            $display("FAIL post_reset_beat: got valid=%b data=%h last=%b, expected 1 %h %b",
                     rd_valid, rd_data, rd_last, e.data, e.last);
        end
        @(negedge clk);
        vectors++;
        if (rd_valid !== 1'b0 || rd_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_end: got valid=%b busy=%b, expected 0 0", rd_valid, rd_busy);
        end
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) regs[i] = 32'h10 + i;
        test_reset();
        test_burst("burst_2_3", 2, 3);
        test_burst("wrap_5_4", 5, 4);
        test_burst("clamp_3_7", 3, 7);
        test_burst("single_6_0", 6, 0);
        test_backpressure();
        test_error();
        test_back_to_back();
        test_bypass_snapshot();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
